// File: rtl/arbitro_pkg.sv
// Shared encodings for the weighted round-robin arbiter: port count, destination
// field width and FSM state type.
package arbitro_pkg;
  localparam int N_PORTS = 4;
  localparam int DEST_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;
endpackage

// File: rtl/arbitro_wrr_rr_pick.sv
// Rotating priority encoder: returns the first requester found scanning
// ptr, ptr+1, ... modulo the port count.
module rr_pick
  import arbitro_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         idx,
  output logic               any
);

  always_comb begin
    idx = ptr;
    any = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        idx = ptr + 2'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_wrr.sv
// Weighted round-robin arbiter moving one word per cycle from four show-ahead
// input FIFOs to four output FIFOs, with backpressure and a stall timeout.
module arbitro_wrr
  import arbitro_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int DEST_LSB    = 10,
  parameter int STALL_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N_PORTS*DATA_W-1:0] fifo_data,
  input  logic [N_PORTS-1:0]        empty,
  input  logic [N_PORTS-1:0]        almost_full,
  input  logic [2*N_PORTS-1:0]      weights,
  output logic [N_PORTS-1:0]        pop,
  output logic [N_PORTS-1:0]        push,
  output logic [DATA_W-1:0]         data_out,
  output logic [1:0]                grant,
  output logic                      busy
);

  state_e      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  q_q, q_d;
  logic [7:0]  stall_q, stall_d;

  logic [DATA_W-1:0] head;
  logic [DEST_W-1:0] dest;
  logic [1:0]        pick_idx;
  logic              pick_any;
  logic [1:0]        pick_wt;

  assign head    = fifo_data[int'(grant_q)*DATA_W +: DATA_W];
  assign dest    = head[DEST_LSB +: DEST_W];
  assign pick_wt = weights[int'(pick_idx)*2 +: 2];

  rr_pick u_pick (
    .req (~empty),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    q_d      = q_q;
    stall_d  = stall_q;
    pop      = '0;
    push     = '0;
    data_out = '0;
    // Gating on reset keeps the combinational outputs quiet in a reset cycle.
    if (!reset && en) begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_d = pick_idx;
            q_d     = pick_wt;
            stall_d = '0;
            state_d = SERVE;
          end
        end
        SERVE: begin
          if (empty[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q + 2'd1;
          end else if (almost_full[dest]) begin
            stall_d = stall_q + 8'd1;
            if (stall_q == 8'(STALL_LIMIT - 1)) begin
              state_d  = IDLE;
              rr_ptr_d = grant_q + 2'd1;
            end
          end else begin
            pop[grant_q] = 1'b1;
            push[dest]   = 1'b1;
            data_out     = head;
            stall_d      = '0;
            if (q_q == 2'd0) begin
              state_d  = IDLE;
              rr_ptr_d = grant_q + 2'd1;
            end else begin
              q_d = q_q - 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      q_q      <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      q_q      <= q_d;
      stall_q  <= stall_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == SERVE);

endmodule

// File: tb/tb_arbitro_wrr.sv
// Randomized bench for arbitro_wrr: a quantum/stall reference model predicts each
// transfer into a scoreboard queue that an independent monitor drains.
module tb_arbitro_wrr;
  localparam int DATA_W      = 12;
  localparam int DEST_LSB    = 10;
  localparam int STALL_LIMIT = 8;
  localparam int N_CYC       = 4000;
  localparam int DEPTH       = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [4*DATA_W-1:0] fifo_data;
  logic [3:0]        empty;
  logic [3:0]        almost_full;
  logic [7:0]        weights;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant;
  logic              busy;

  arbitro_wrr #(
    .DATA_W      (DATA_W),
    .DEST_LSB    (DEST_LSB),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .fifo_data   (fifo_data),
    .empty       (empty),
    .almost_full (almost_full),
    .weights     (weights),
    .pop         (pop),
    .push        (push),
    .data_out    (data_out),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [DATA_W-1:0] data;
  } xfer_t;

  xfer_t             exp_q[$];
  logic [DATA_W-1:0] fq[4][$];

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  // Reference model: serving flag, owner, words left in quantum, next start point.
  bit m_serving = 1'b0;
  int m_owner   = 0;
  int m_left    = 0;
  int m_next    = 0;
  int m_stalls  = 0;
  int exp_grant = 0;
  bit exp_busy  = 1'b0;
  int pend_pop  = -1;

  task automatic release_grant();
    m_serving = 1'b0;
    m_next    = (m_owner + 1) % 4;
  endtask

  task automatic drive_fifos();
    for (int p = 0; p < 4; p++) begin
      empty[p] = (fq[p].size() == 0);
      fifo_data[p*DATA_W +: DATA_W] = (fq[p].size() != 0) ? fq[p][0] : '0;
    end
  endtask

  task automatic run_model();
    logic [DATA_W-1:0] w;
    int d;
    int p;
    xfer_t e;
    if (reset) begin
      m_serving = 1'b0;
      m_owner   = 0;
      m_next    = 0;
      m_left    = 0;
      m_stalls  = 0;
    end else if (en) begin
      if (!m_serving) begin
        for (int k = 0; k < 4; k++) begin
          p = (m_next + k) % 4;
          if (fq[p].size() != 0) begin
            m_owner   = p;
            m_left    = int'(weights[2*p +: 2]) + 1;
            m_stalls  = 0;
            m_serving = 1'b1;
            break;
          end
        end
      end else if (fq[m_owner].size() == 0) begin
        release_grant();
      end else begin
        w = fq[m_owner][0];
        d = int'(w[DEST_LSB +: 2]);
        if (almost_full[d]) begin
          m_stalls++;
          if (m_stalls >= STALL_LIMIT) release_grant();
        end else begin
          e.pop  = 4'(1 << m_owner);
          e.push = 4'(1 << d);
          e.data = w;
          exp_q.push_back(e);
          pend_pop = m_owner;
          m_stalls = 0;
          m_left--;
          if (m_left == 0) release_grant();
        end
      end
    end
  endtask

  task automatic check_leftover();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_xfer: got no push, expected pop=%b push=%b data=%h",
               exp_q[0].pop, exp_q[0].push, exp_q[0].data);
      exp_q.delete();
    end
  endtask

  function automatic logic [DATA_W-1:0] gen_word(int dest_force);
    logic [DATA_W-1:0] w;
    w = DATA_W'($urandom_range(0, 4095));
    if (dest_force >= 0) w[DEST_LSB +: 2] = 2'(dest_force);
    return w;
  endfunction

  // Stimulus and model
  initial begin
    int phase;
    int feed_pct;
    int dest_force;
    reset       = 1'b1;
    en          = 1'b1;
    almost_full = '0;
    weights     = '0;
    drive_fifos();
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk);
      #1;
      if (pend_pop >= 0) begin
        void'(fq[pend_pop].pop_front());
        pend_pop = -1;
      end
      exp_grant = m_owner;
      exp_busy  = m_serving;
      check_leftover();
      started = 1'b1;

      phase      = (c / 500) % 8;
      feed_pct   = 50;
      dest_force = -1;
      reset      = (c < 2);
      en         = 1'b1;
      almost_full = '0;
      if ($urandom_range(0, 9) == 0) weights = 8'($urandom);
      case (phase)
        0: begin feed_pct = 50; weights = 8'h00; end
        1: begin feed_pct = 85; dest_force = 0; weights = 8'b00_01_10_11; end
        2: almost_full = 4'($urandom) & 4'($urandom);
        3: begin
          almost_full = 4'b1000;
          if ($urandom_range(0, 1) == 0) dest_force = 3;
        end
        4: begin feed_pct = 20; weights = 8'hFF; end
        5: begin
          en = ($urandom_range(0, 9) < 7);
          almost_full = 4'($urandom) & 4'($urandom) & 4'($urandom);
        end
        6: begin
          almost_full = 4'($urandom) & 4'($urandom);
          en = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 49) == 0) reset = 1'b1;
        end
        default: begin
          en = ($urandom_range(0, 3) != 0);
          almost_full = 4'($urandom) & 4'($urandom);
        end
      endcase
      for (int p = 0; p < 4; p++) begin
        if (phase == 0 && p != 0) continue;
        if (fq[p].size() < DEPTH && $urandom_range(0, 99) < feed_pct)
          fq[p].push_back(gen_word(dest_force));
      end
      drive_fifos();
      run_model();
    end
    @(posedge clk);
    #1;
    check_leftover();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        vectors++;
        if (grant !== 2'(exp_grant)) begin
          miscompares++;
          $display("FAIL grant: got %0d expected %0d at %0t", grant, exp_grant, $time);
        end
        vectors++;
        if (busy !== exp_busy) begin
          miscompares++;
          $display("FAIL busy: got %0b expected %0b at %0t", busy, exp_busy, $time);
        end
        vectors++;
        if (push !== 4'b0) begin
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_xfer: got pop=%b push=%b data=%h expected none at %0t",
                     pop, push, data_out, $time);
          end else begin
            e = exp_q.pop_front();
            if (pop !== e.pop || push !== e.push || data_out !== e.data) begin
              miscompares++;
              $display("FAIL xfer: got pop=%b push=%b data=%h expected pop=%b push=%b data=%h at %0t",
                       pop, push, data_out, e.pop, e.push, e.data, $time);
            end
          end
        end else if (pop !== 4'b0 || data_out !== '0) begin
          miscompares++;
          $display("FAIL idle_outputs: got pop=%b data=%h expected 0 at %0t",
                   pop, data_out, $time);
        end
      end
    end
  end

endmodule

// File: doc/arbitro_wrr.md
Name: arbitro_wrr

Overview:
- Weighted round-robin arbiter between four input FIFOs (P0..P3) and four output FIFOs, in the same arbiter stage as the existing fixed-priority arbiter.
- Pops one 12-bit word per cycle from the granted input FIFO and pushes it to the output FIFO named by the word's destination field.
- Honours downstream almost_full backpressure.
- Limits head-of-line blocking with a stall timeout that releases a blocked grant.

Parameters:
- DATA_W, 12: word width.
- DEST_LSB, 10: LSB of the 2-bit destination field; dest = word[DEST_LSB+1:DEST_LSB].
- STALL_LIMIT, 8: consecutive stalled SERVE cycles before a forced grant release, 1..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  arbiter enable; 0 freezes the FSM and suppresses all transfers.
- fifo_data  in  4*DATA_W  head words of the input FIFOs, P0 in bits [DATA_W-1:0]. FIFOs are show-ahead: the head is valid while !empty.
- empty  in  4  input FIFO empty flags.
- almost_full  in  4  output FIFO almost_full flags.
- weights  in  8  quantum per input, 2 bits each (P0 in [1:0]); quantum = w+1 words.
- pop  out  4  one-hot pop to input FIFOs, combinational.
- push  out  4  one-hot push to output FIFOs, combinational.
- data_out  out  DATA_W  word being pushed; 0 when push==0.
- grant  out  2  index of the current or last granted input, registered.
- busy  out  1  1 while in SERVE, registered.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0, q=0, stall_cnt=0, busy=0, pop=0, push=0, data_out=0. Reset dominates every other input.
- State registers: state {IDLE, SERVE}, rr_ptr[1:0], grant[1:0], q[1:0] (remaining words minus 1), stall_cnt[7:0].
- IDLE, en=1, any !empty:
  - Pick the first non-empty input scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Set grant to that input, q=weights[grant], stall_cnt=0, next state SERVE.
  - No transfer happens in the IDLE cycle, so grant-to-first-pop latency is 1 cycle.
- IDLE, no input non-empty or en=0: hold.
- SERVE, en=1, dest=fifo_data[grant] destination field:
  - Transfer when !empty[grant] && !almost_full[dest]: pop[grant]=1, push[dest]=1, data_out=head, stall_cnt=0.
    - If q==0: release, rr_ptr=grant+1, go IDLE.
    - Else: q=q-1.
  - Empty when empty[grant]=1: no transfer. Release with rr_ptr=grant+1, go IDLE. Unused quantum is lost.
  - Stall when !empty[grant] && almost_full[dest]: no pop/push, q held, stall_cnt+1.
    - When stall_cnt reaches STALL_LIMIT-1 in a stall cycle: release with rr_ptr=grant+1, go IDLE.
- SERVE, en=0: pop=push=0, all registers hold, stall_cnt not incremented.
- almost_full, empty and fifo_data are sampled combinationally in the transfer cycle. A flag rising in the same cycle blocks that transfer.
- weights are sampled only on the IDLE->SERVE load. Changes mid-quantum have no effect.
- At most one pop and one push per cycle. pop and push are one-hot or zero, and always asserted together.
- Peak throughput is 1 word/cycle within a quantum. Each grant change costs 1 idle cycle.
- busy=(state==SERVE).
- grant keeps its value in IDLE until the next load.
- rr_ptr wraps 3->0.
- Reset asserted mid-quantum: the outputs are already 0 in the reset cycle and no pop occurs.

Decomposition:
- Package arbitro_pkg: state encoding (IDLE=0, SERVE=1), DEST field width 2, N_PORTS=4.
- Sub-module rr_pick: combinational rotating priority encoder. Inputs are req[3:0] and ptr[1:0]; outputs are idx[1:0] and any.
- arbitro_wrr instantiates rr_pick once and holds the FSM, counters and data mux.

Test Plan:
- Single source: empty=4'b1110, weights=0, P0 head 12'h896 (dest 2), all almost_full=0 → pop=0001/push=0100 once every 2 cycles, data_out=12'h896, grant=0.
- Weighted RR: all non-empty, weights=8'b00_01_10_11, heads route to dest 0 → bursts of 4,3,2,1 pops for P0,P1,P2,P3 with one idle cycle between; rr_ptr wraps back to P0.
- Backpressure: P1 granted, head dest 2, almost_full[2]=1 for 3 cycles → no pop/push, q unchanged, busy=1; transfer resumes the cycle after the flag drops.
- Stall timeout: STALL_LIMIT=8, almost_full[3] held high, P0 head dest 3, P1 non-empty → P0 released after 8 stall cycles; P1 is granted 1 cycle later.
- Early empty: P2 granted with weight 3, empty[2] rises after 2 pops → release, rr_ptr=3, next grant goes to P3 if non-empty.
- Reset/enable: en=0 mid-burst → pop=push=0, registers held; reset mid-burst → all outputs 0 in that cycle and state=IDLE, rr_ptr=0.
